// File: rtl/udm_bus_pkg.sv
// Shared widths and helpers for UDM MemSplit32 bus slaves.
// be_merge builds the word left behind by a byte-enabled write.
package udm_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  function automatic logic [BUS_DW-1:0] be_merge(
    input logic [BUS_DW-1:0]  old_word,
    input logic [BUS_DW-1:0]  wdata,
    input logic [BUS_BEW-1:0] be
  );
    logic [BUS_DW-1:0] res;
    res = old_word;
    for (int k = 0; k < BUS_BEW; k++) begin
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/udm_resp_pipe.sv
// Valid/data delay line for bus read responses, DEPTH register stages.
// Data is held at zero whenever its valid bit is clear, so idle outputs can be OR-combined.
module udm_resp_pipe #(
  parameter int DW    = 32,
  parameter int DEPTH = 1
) (
  input  logic          clk_i,
  input  logic          clr_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][DW-1:0] dat_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= valid_i ? data_i : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/udm_csr_bank.sv
// Control/status register bank on the UDM debug bus: NUM_RW writable plus
// NUM_RO read-only words at BASE_ADDR, with byte-enable writes and write strobes.
module udm_csr_bank
  import udm_bus_pkg::*;
#(
  parameter logic [BUS_AW-1:0]        BASE_ADDR  = '0,
  parameter int                       NUM_RW     = 4,
  parameter int                       NUM_RO     = 2,
  parameter logic [NUM_RW*BUS_DW-1:0] RST_VAL    = '0,
  parameter int                       RD_LATENCY = 1,
  // keeps ro_regs_bi at least one word wide when NUM_RO = 0
  localparam int                      RO_N       = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bus_req_i,
  input  logic                       bus_we_i,
  input  logic [BUS_AW-1:0]          bus_addr_bi,
  input  logic [BUS_BEW-1:0]         bus_be_bi,
  input  logic [BUS_DW-1:0]          bus_wdata_bi,
  output logic                       bus_ack_o,
  output logic                       bus_resp_o,
  output logic [BUS_DW-1:0]          bus_rdata_bo,
  output logic [NUM_RW*BUS_DW-1:0]   rw_regs_bo,
  output logic [NUM_RW-1:0]          rw_wr_pulse_o,
  input  logic [RO_N*BUS_DW-1:0]     ro_regs_bi
);

  localparam int                NUM_ALL = NUM_RW + NUM_RO;
  localparam logic [BUS_AW-1:0] SPAN    = BUS_AW'(4 * NUM_ALL);

  logic [BUS_AW-1:0]        off;
  logic [BUS_AW-3:0]        idx;
  logic                     hit;
  logic                     wr_acc;
  logic                     rd_acc;
  logic [BUS_DW-1:0]        rd_sel;
  logic [NUM_RW*BUS_DW-1:0] rw_q;
  logic [NUM_RW-1:0]        pulse_q;
  logic                     unused_addr_lsb;

  // Unsigned wrap makes every address below BASE_ADDR look far out of range.
  assign off             = bus_addr_bi - BASE_ADDR;
  assign hit             = (off < SPAN);
  assign idx             = off[BUS_AW-1:2];
  assign unused_addr_lsb = ^off[1:0];

  assign bus_ack_o = bus_req_i & hit;
  assign wr_acc    = bus_ack_o & bus_we_i;
  assign rd_acc    = bus_ack_o & ~bus_we_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rw_q    <= RST_VAL;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_acc && (idx == (BUS_AW-2)'(i))) begin
          rw_q[i*BUS_DW +: BUS_DW] <= be_merge(rw_q[i*BUS_DW +: BUS_DW], bus_wdata_bi, bus_be_bi);
          pulse_q[i]               <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx == (BUS_AW-2)'(i)) rd_sel = rw_q[i*BUS_DW +: BUS_DW];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (idx == (BUS_AW-2)'(NUM_RW + j)) rd_sel = ro_regs_bi[j*BUS_DW +: BUS_DW];
    end
  end

  // Reset doubles as the pipe clear so in-flight responses are dropped.
  udm_resp_pipe #(
    .DW    (BUS_DW),
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .clr_ni  (rst_ni),
    .valid_i (rd_acc),
    .data_i  (rd_sel),
    .valid_o (bus_resp_o),
    .data_o  (bus_rdata_bo)
  );

  assign rw_regs_bo    = rw_q;
  assign rw_wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_udm_csr_bank.sv
// Directed bench for udm_csr_bank: four instances at read latencies 1..4 share one
// bus, plus a small bank placed at the top of the address space to exercise wrap.
module tb_udm_csr_bank;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [3:0]   be;
  logic [31:0]  wdata;
  logic [63:0]  ro;
  logic [31:0]  ro_w;

  logic [3:0]             ack;
  logic [3:0]             resp;
  logic [3:0][31:0]       rdata;
  logic [3:0][127:0]      rw_regs;
  logic [3:0][3:0]        pulse;

  logic         ack_w;
  logic         resp_w;
  logic [31:0]  rdata_w;
  logic [31:0]  regs_w;
  logic [0:0]   pulse_w;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] RST_MAIN = {32'h0, 32'h0, 32'h0, 32'h0000FFFF};

  for (genvar g = 0; g < 4; g++) begin : g_lat
    udm_csr_bank #(
      .BASE_ADDR  (32'h00000100),
      .NUM_RW     (4),
      .NUM_RO     (2),
      .RST_VAL    (RST_MAIN),
      .RD_LATENCY (g + 1)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .bus_req_i     (req),
      .bus_we_i      (we),
      .bus_addr_bi   (addr),
      .bus_be_bi     (be),
      .bus_wdata_bi  (wdata),
      .bus_ack_o     (ack[g]),
      .bus_resp_o    (resp[g]),
      .bus_rdata_bo  (rdata[g]),
      .rw_regs_bo    (rw_regs[g]),
      .rw_wr_pulse_o (pulse[g]),
      .ro_regs_bi    (ro)
    );
  end

  udm_csr_bank #(
    .BASE_ADDR  (32'hFFFFFFF8),
    .NUM_RW     (1),
    .NUM_RO     (1),
    .RST_VAL    (32'h5A5A0000),
    .RD_LATENCY (1)
  ) u_wrap (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus_req_i     (req),
    .bus_we_i      (we),
    .bus_addr_bi   (addr),
    .bus_be_bi     (be),
    .bus_wdata_bi  (wdata),
    .bus_ack_o     (ack_w),
    .bus_resp_o    (resp_w),
    .bus_rdata_bo  (rdata_w),
    .rw_regs_bo    (regs_w),
    .rw_wr_pulse_o (pulse_w),
    .ro_regs_bi    (ro_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [3:0]  pulse;
    logic        resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
  } wvec_t;

  vec_t  vecs[16];
  wvec_t wvecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
  endtask

  initial begin
    // we, addr, be, wdata | ack, pulse, resp, rdata (latency-1 instance)
    vecs[0]  = '{1'b0, 32'h100, 4'hF, 32'h0,        1'b1, 4'b0000, 1'b1, 32'h0000FFFF};
    vecs[1]  = '{1'b1, 32'h104, 4'hF, 32'h11223344, 1'b1, 4'b0010, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h104, 4'h5, 32'hAABBCCDD, 1'b1, 4'b0010, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h104, 4'h0, 32'h0,        1'b1, 4'b0000, 1'b1, 32'h11BB33DD};
    vecs[4]  = '{1'b1, 32'h100, 4'h0, 32'hFFFFFFFF, 1'b1, 4'b0001, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h102, 4'hF, 32'h0,        1'b1, 4'b0000, 1'b1, 32'h0000FFFF};
    vecs[6]  = '{1'b1, 32'h108, 4'hF, 32'h3,        1'b1, 4'b0100, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h110, 4'hF, 32'h0,        1'b1, 4'b0000, 1'b1, 32'hCAFE0001};
    vecs[8]  = '{1'b1, 32'h110, 4'hF, 32'hDEAD0000, 1'b1, 4'b0000, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h114, 4'hF, 32'h0,        1'b1, 4'b0000, 1'b1, 32'hBEEF0002};
    vecs[10] = '{1'b0, 32'h0FC, 4'hF, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h118, 4'hF, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h118, 4'hF, 32'h55555555, 1'b0, 4'b0000, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h10C, 4'hF, 32'h4,        1'b1, 4'b1000, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h100, 4'hF, 32'h1,        1'b1, 4'b0001, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h104, 4'hF, 32'h2,        1'b1, 4'b0010, 1'b0, 32'h0};

    wvecs[0] = '{32'hFFFFFFF8, 1'b1, 32'h5A5A0000};
    wvecs[1] = '{32'hFFFFFFFC, 1'b1, 32'h0BADF00D};
    wvecs[2] = '{32'h00000000, 1'b0, 32'h0};
    wvecs[3] = '{32'hFFFFFFF4, 1'b0, 32'h0};
    wvecs[4] = '{32'h00000008, 1'b0, 32'h0};

    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    be    = '0;
    wdata = '0;
    ro    = {32'hBEEF0002, 32'hCAFE0001};
    ro_w  = 32'h0BADF00D;

    repeat (3) @(negedge clk);
    chk("rst_resp",  32'(resp[0]),         32'h0);
    chk("rst_resp4", 32'(resp[3]),         32'h0);
    chk("rst_rdata", rdata[0],             32'h0);
    chk("rst_pulse", 32'(pulse[0]),        32'h0);
    chk("rst_reg0",  rw_regs[0][31:0],     32'h0000FFFF);
    chk("rst_reg1",  rw_regs[0][63:32],    32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_idle_resp", i),  32'(resp[0]),  32'h0);
      chk($sformatf("v%0d_idle_rdata", i), rdata[0],      32'h0);
      chk($sformatf("v%0d_idle_pulse", i), 32'(pulse[0]), 32'h0);
      drive(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      #1;
      chk($sformatf("v%0d_ack", i), 32'(ack[0]), 32'(vecs[i].ack));
      @(negedge clk);
      req = 1'b0;
      chk($sformatf("v%0d_pulse", i), 32'(pulse[0]), 32'(vecs[i].pulse));
      chk($sformatf("v%0d_resp", i),  32'(resp[0]),  32'(vecs[i].resp));
      chk($sformatf("v%0d_rdata", i), rdata[0],      vecs[i].rdata);
    end
    chk("reg1_merged_kept", rw_regs[0][63:32], 32'h2);

    // back-to-back reads of reg0..reg3 (1,2,3,4) on every latency
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        int k;
        k = c - (g + 1);
        chk($sformatf("lat%0d_c%0d_resp", g + 1, c), 32'(resp[g]),
            (k >= 0 && k < 4) ? 32'h1 : 32'h0);
        chk($sformatf("lat%0d_c%0d_rdata", g + 1, c), rdata[g],
            (k >= 0 && k < 4) ? 32'(k + 1) : 32'h0);
      end
      if (c < 4) drive(1'b0, 32'h100 + 32'(4 * c), 4'hF, 32'h0);
      else req = 1'b0;
    end

    @(negedge clk);
    drive(1'b1, 32'h108, 4'hF, 32'h00000077);
    @(negedge clk);
    chk("raw_pulse", 32'(pulse[0]), 32'h4);
    drive(1'b0, 32'h108, 4'h0, 32'h0);
    @(negedge clk);
    req = 1'b0;
    chk("raw_resp",  32'(resp[0]), 32'h1);
    chk("raw_rdata", rdata[0],     32'h00000077);

    @(negedge clk);
    ro[31:0] = 32'hCAFE0001;
    drive(1'b0, 32'h110, 4'hF, 32'h0);
    @(negedge clk);
    ro[31:0] = 32'h12345678;
    req = 1'b0;
    chk("ro_sample", rdata[0], 32'hCAFE0001);
    @(negedge clk);
    drive(1'b0, 32'h110, 4'hF, 32'h0);
    @(negedge clk);
    req = 1'b0;
    chk("ro_resample", rdata[0], 32'h12345678);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b0, wvecs[i].addr, 4'hF, 32'h0);
      #1;
      chk($sformatf("wrap%0d_ack", i), 32'(ack_w), 32'(wvecs[i].ack));
      @(negedge clk);
      req = 1'b0;
      chk($sformatf("wrap%0d_resp", i),  32'(resp_w), 32'(wvecs[i].ack));
      chk($sformatf("wrap%0d_rdata", i), rdata_w,     wvecs[i].rdata);
    end

    // reset one cycle after a latency-3 read is accepted
    @(negedge clk);
    drive(1'b0, 32'h100, 4'hF, 32'h0);
    @(negedge clk);
    req   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_resp3_0", 32'(resp[2]), 32'h0);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_resp3_%0d", c), 32'(resp[2]), 32'h0);
      chk($sformatf("midrst_resp4_%0d", c), 32'(resp[3]), 32'h0);
    end
    chk("midrst_pulse", 32'(pulse[0]), 32'h0);
    drive(1'b0, 32'h100, 4'hF, 32'h0);
    @(negedge clk);
    req = 1'b0;
    chk("post_rst_resp",  32'(resp[0]), 32'h1);
    chk("post_rst_rdata", rdata[0],     32'h0000FFFF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udm_csr_bank.md
# udm_csr_bank

Parametrised control/status register bank for the UDM debug bus (MemSplit32 protocol). It replaces hand-written per-register decode in board top levels with a single slave of NUM_RW writable and NUM_RO read-only 32-bit registers at a configurable base address. It adds byte-enable writes, per-register write strobes for attached datapaths, and a configurable-latency read response pipeline. Outputs are zero when idle, so several instances and memories can be OR-combined onto one bus.

## Interface
- BASE_ADDR, 32'h00000000, byte address of register 0; must be 4-byte aligned.
- NUM_RW, 4, number of read/write registers (1..64).
- NUM_RO, 2, number of read-only registers (0..64).
- RST_VAL, '0, packed NUM_RW*32-bit reset values; register i is at bits [32*i+31:32*i].
- RD_LATENCY, 1, cycles from accepted read to bus_resp_o (1..4).
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; one clock, reset is synchronous and active-low.
- bus_req_i  in  1  request valid.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_bi  in  32  byte address.
- bus_be_bi  in  4  byte enables; bit k covers wdata[8k+7:8k].
- bus_wdata_bi  in  32  write data.
- bus_ack_o  out  1  request accepted (combinational).
- bus_resp_o  out  1  read data valid.
- bus_rdata_bo  out  32  read data; 0 when bus_resp_o = 0.
- rw_regs_bo  out  NUM_RW*32  current RW register contents.
- rw_wr_pulse_o  out  NUM_RW  one-cycle strobe per RW register on a write.
- ro_regs_bi  in  NUM_RO*32  read-only values, sampled at read acceptance.

## Operation
- Decode: off = bus_addr_bi - BASE_ADDR (32-bit unsigned). hit = off < 4*(NUM_RW+NUM_RO). idx = off[31:2]. bus_addr_bi[1:0] is ignored.
- idx < NUM_RW selects RW register idx. Otherwise RO register idx-NUM_RW is selected.
- bus_ack_o = bus_req_i & hit. Misses are never acked; another slave or the UDM timeout handles them.
- Accepted write to RW register i:
  - each byte k with bus_be_bi[k] = 1 is replaced; other bytes keep their value;
  - rw_wr_pulse_o[i] = 1 for exactly one cycle, even if be = 4'b0000.
- Accepted write to an RO index: acked, no state change, no pulse.
- Accepted read: the selected value is captured into stage 0 of the response pipe. Byte enables are ignored on reads.
  - RW reads return the register value before the edge. A write is never concurrent, since there is one request per cycle.
  - RO reads return ro_regs_bi as sampled in the accept cycle.
- Response pipe: RD_LATENCY stages of {valid, data}. The last stage drives bus_resp_o and bus_rdata_bo, with data gated by valid.
- Throughput: one accepted request per cycle, any mix of reads and writes. There is no backpressure.

## Timing
- Reset (rst_ni = 0 at an edge):
  - RW registers load RST_VAL;
  - rw_wr_pulse_o = 0, all pipe valid bits = 0, bus_resp_o = 0, bus_rdata_bo = 0;
  - in-flight read responses are dropped and never delivered;
  - bus_ack_o stays combinational but has no effect while in reset: writes are ignored and reads are not captured.
- Write accepted at edge N:
  - new value visible on rw_regs_bo after edge N;
  - rw_wr_pulse_o high during cycle N+1 only.
- Read accepted at edge N: bus_resp_o high during cycle N+RD_LATENCY, i.e. registered after edge N+RD_LATENCY-1.
- Reading a register in the cycle right after a write to it returns the new value.
- Back-to-back reads produce back-to-back responses, in order.
- Address wrap: with BASE_ADDR near 32'hFFFFFFFC, off wraps. Any address below BASE_ADDR produces a large off and therefore a miss.

## Structure
- Package udm_bus_pkg holds:
  - BUS_AW = 32, BUS_DW = 32, BUS_BEW = 4;
  - a function be_merge(old, wdata, be) returning the byte-merged word.
- Sub-module udm_resp_pipe (params DW, DEPTH): valid/data delay line with synchronous active-low clear. It is reusable for testmem-style slaves.
- udm_csr_bank contains the decode, the RW register array, the pulse register and the read mux.

## Test plan
- Reset with RST_VAL = {32'h0, 32'h0, 32'h0, 32'hFFFF}: after release, read at BASE+0 returns 32'h0000FFFF; rw_wr_pulse_o = 0.
- Byte-enable write: reg1 = 32'h11223344, then write 32'hAABBCCDD with be = 4'b0101. Required: reg1 = 32'h11BB33DD and rw_wr_pulse_o = 4'b0010 for one cycle.
- Latency sweep, RD_LATENCY = 1..4, four back-to-back reads of reg0..reg3 holding 1, 2, 3, 4:
  - responses appear on consecutive cycles starting RD_LATENCY cycles after the first accept;
  - data is 1, 2, 3, 4 in order.
- RO sampling, ro_regs_bi[0] = 32'hCAFE0001 at accept and changed next cycle: response = 32'hCAFE0001. A write to the RO index is acked with no pulse.
- Misses with BASE_ADDR = 32'h100, NUM_RW = 4, NUM_RO = 2: addresses 32'hFC and 32'h118 give bus_ack_o = 0 and no resp. 32'h114 is acked. bus_rdata_bo stays 0 while idle.
- Reset mid-read, RD_LATENCY = 3: read accepted, rst_ni = 0 one cycle later. Required: bus_resp_o never asserts for that read.
